// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multicycle MIPS main controller: FSM states, opcodes,
// datapath select encodings and the control output bundle.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       trap;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational map from controller state (and memory handshake) to the
// datapath control bundle.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                // The PC and IR only load once the fetch has actually completed.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB: ctrl.reg_write = 1'b1;
            S_TRAP:    ctrl.trap      = 1'b1;
            default:   ctrl           = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: state register, opcode dispatch, retired
// instruction counter and reset gating of every control output.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] Opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             trap,
    output logic [31:0]      instr_retired
);

    state_t state;
    logic   is_store;
    logic   retire;
    ctrl_t  ctrl;
    ctrl_t  gated;
    logic   unused_zero;

    // The branch condition is applied in the datapath, never in the FSM.
    assign unused_zero = zero;

    mips_ctrl_decode u_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    always_comb begin
        retire = 1'b0;
        case (state)
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
            S_MEM_WR: retire = mem_ready;
            default:  retire = 1'b0;
        endcase
    end

    // Opcode is only looked at in DECODE, so lw/sw is remembered for MEM_ADDR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_FETCH;
            is_store      <= 1'b0;
            instr_retired <= '0;
        end else begin
            instr_retired <= instr_retired + {31'b0, retire};
            case (state)
                S_FETCH: if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    is_store <= (Opcode == OP_SW);
                    case (Opcode)
                        OP_LW, OP_SW: state <= S_MEM_ADDR;
                        OP_RTYPE:     state <= S_EXEC_R;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_J:         state <= S_JUMP;
                        OP_ADDI:      state <= S_ADDI_EX;
                        default:      state <= S_TRAP;
                    endcase
                end
                S_MEM_ADDR: state <= is_store ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (mem_ready) state <= S_MEM_WB;
                S_MEM_WR:   if (mem_ready) state <= S_FETCH;
                S_EXEC_R:   state <= S_R_WB;
                S_ADDI_EX:  state <= S_ADDI_WB;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Strobes drop combinationally with rst_n so an aborted access cannot write.
    assign gated = rst_n ? ctrl : '0;

    assign PCWrite     = gated.pc_write;
    assign PCWriteCond = gated.pc_write_cond;
    assign IorD        = gated.ior_d;
    assign MemRead     = gated.mem_read;
    assign MemWrite    = gated.mem_write;
    assign IRWrite     = gated.ir_write;
    assign MemtoReg    = gated.mem_to_reg;
    assign RegDst      = gated.reg_dst;
    assign RegWrite    = gated.reg_write;
    assign ALUSrcA     = gated.alu_src_a;
    assign ALUSrcB     = gated.alu_src_b;
    assign ALUOp       = gated.alu_op;
    assign PCSource    = gated.pc_source;
    assign trap        = gated.trap;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback, one step per clock. It replaces the single-cycle combinational control, so one shared memory and one ALU can be reused across cycles. Memory accesses stall on `mem_ready`. Undefined opcodes lock the controller in a trap state.

## Interface
Parameters:
- `OPC_W`, 6: opcode width.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `Opcode`  in  6  `IR[31:26]`; valid from the DECODE state onward.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  shared memory has completed the current access this cycle.
- `PCWrite`  out  1  unconditional PC load.
- `PCWriteCond`  out  1  PC load qualified by `zero`.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite`  out  1  memory strobes.
- `IRWrite`  out  1  instruction register load.
- `MemtoReg`  out  1  register write data select: 1 = MDR.
- `RegDst`  out  1  destination register select: 1 = rd.
- `RegWrite`  out  1  register file write enable.
- `ALUSrcA`  out  1  ALU A operand: 0 = PC, 1 = A.
- `ALUSrcB`  out  2  ALU B operand: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `ALUOp`  out  2  00 = add, 01 = subtract, 10 = funct-decoded.
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump address.
- `trap`  out  1  illegal opcode detected; sticky until reset.
- `instr_retired`  out  32  count of completed instructions.

## Operation
States and required outputs (any output not listed is 0):
- FETCH: `MemRead`, `ALUSrcB`=01. `IRWrite` and `PCWrite` assert only when `mem_ready`=1. Advances to DECODE when `mem_ready`=1; otherwise holds.
- DECODE: `ALUSrcB`=11. Next state by `Opcode`:
  - 100011 / 101011 → MEM_ADDR
  - 000000 → EXEC_R
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EX
  - any other value → TRAP
- MEM_ADDR: `ALUSrcA`=1, `ALUSrcB`=10. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `MemRead`, `IorD`. Goes to MEM_WB when `mem_ready`=1; otherwise holds.
- MEM_WB: `RegWrite`, `MemtoReg`, `RegDst`=0. Goes to FETCH.
- MEM_WR: `MemWrite`, `IorD`. Goes to FETCH when `mem_ready`=1; otherwise holds.
- EXEC_R: `ALUSrcA`=1, `ALUOp`=10. Goes to R_WB.
- R_WB: `RegWrite`, `RegDst`=1. Goes to FETCH.
- BRANCH: `ALUSrcA`=1, `ALUOp`=01, `PCWriteCond`, `PCSource`=01. Goes to FETCH.
- JUMP: `PCWrite`, `PCSource`=10. Goes to FETCH.
- ADDI_EX: `ALUSrcA`=1, `ALUSrcB`=10. Goes to ADDI_WB.
- ADDI_WB: `RegWrite`, `RegDst`=0. Goes to FETCH.
- TRAP: all strobes 0, `trap`=1. Terminal; only reset leaves it.

Retirement counting:
- `instr_retired` increments by 1 on the last cycle of each instruction: MEM_WB, the accepted MEM_WR cycle, R_WB, BRANCH, JUMP, ADDI_WB.
- The counter wraps from 0xFFFFFFFF to 0.
- TRAP never increments it.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - state → FETCH; `instr_retired` → 0; `trap` → 0.
  - Every control output is forced to 0 while `rst_n`=0, even though the state is FETCH.
- After `rst_n` rises, the first rising edge samples FETCH behaviour normally.
- Cycle counts with `mem_ready` always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle `mem_ready`=0 during FETCH, MEM_RD or MEM_WR adds one cycle. While stalled, strobes and select outputs stay stable and `PCWrite`/`IRWrite` stay 0.
- `mem_ready` is ignored in every other state.
- `Opcode` is sampled only in DECODE. Changes in other states have no effect.
- `zero` is consumed only by the datapath through `PCWriteCond`; the FSM does not branch on it.
- Reset asserted mid-instruction aborts immediately. No partial write is allowed after `rst_n` falls, because all strobes go to 0 combinationally.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum (4-bit encoding, FETCH = 0);
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_ADDI`);
  - `ALUOp`, `ALUSrcB` and `PCSource` encodings.
- Sub-module `mips_ctrl_decode`: purely combinational map from (state, `mem_ready`) to the control output bundle.
- Top level: the state register, next-state logic, the retire counter and the reset gating.

## Test plan
- Reset held 3 cycles, then released with `mem_ready`=1: all outputs are 0 during reset. The first cycle after release shows FETCH with `MemRead`=1, `ALUSrcB`=01, `PCWrite`=`IRWrite`=1.
- `Opcode`=100011, `mem_ready`=1: state sequence FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB. `RegWrite`=`MemtoReg`=1 in cycle 5. `instr_retired` goes 0 → 1.
- `Opcode`=101011 with `mem_ready` low for 2 cycles in MEM_WR: `MemWrite`=`IorD`=1 held for 3 cycles. Total 6 cycles. `instr_retired` increments once.
- Back-to-back beq (000100) then j (000010): 3 cycles each. `PCWriteCond`=1 and `ALUOp`=01 in the beq cycle 3; `PCWrite`=1 and `PCSource`=10 in the j cycle 3. Counter reaches 2.
- `Opcode`=111111: TRAP reached at cycle 3. `trap`=1 with all strobes 0 for 10 further cycles; the counter is frozen. Asserting `rst_n`=0 clears `trap`.
- Counter preloaded through a bench force to 0xFFFFFFFF, then one R-type (000000) runs: it wraps to 0. Reset asserted during EXEC_R: no `RegWrite` occurs, and the FSM is in FETCH after release.
